// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM stage bus: EX-side request handshake + payload, MEM-side response
// handshake + payload, and the hazard-unit forwarding tap.
//   master : EX/MEM-side agent (drives in_valid/payload/out_ready)
//   slave  : the pipeline register itself
interface ex_mem_pipe_reg_if #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 10,
  parameter int RegAddrWidth = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    MEM_to_REG_IN;
  logic                    MEM_READ_IN;
  logic                    MEM_WRITE_IN;
  logic                    Reg_EN_IN;
  logic [DataWidth-1:0]    ALU_Result_IN;
  logic [AddrWidth-1:0]    D_MEM_ADDR_IN;
  logic [DataWidth-1:0]    DataIN_MEM_IN;
  logic [RegAddrWidth-1:0] WB_REG_IN;

  logic                    out_valid;
  logic                    out_ready;
  logic                    MEM_to_REG_OUT;
  logic                    MEM_READ_OUT;
  logic                    MEM_WRITE_OUT;
  logic                    Reg_EN_OUT;
  logic [DataWidth-1:0]    ALU_Result_OUT;
  logic [AddrWidth-1:0]    D_MEM_ADDR_OUT;
  logic [DataWidth-1:0]    DataIN_MEM_OUT;
  logic [RegAddrWidth-1:0] WB_REG_OUT;

  logic                    fwd_en;
  logic [RegAddrWidth-1:0] fwd_reg;
  logic [DataWidth-1:0]    fwd_data;
  logic [1:0]              occupancy;

  modport master (
    output in_valid, MEM_to_REG_IN, MEM_READ_IN, MEM_WRITE_IN, Reg_EN_IN,
           ALU_Result_IN, D_MEM_ADDR_IN, DataIN_MEM_IN, WB_REG_IN, out_ready,
    input  in_ready, out_valid, MEM_to_REG_OUT, MEM_READ_OUT, MEM_WRITE_OUT,
           Reg_EN_OUT, ALU_Result_OUT, D_MEM_ADDR_OUT, DataIN_MEM_OUT,
           WB_REG_OUT, fwd_en, fwd_reg, fwd_data, occupancy
  );

  modport slave (
    input  in_valid, MEM_to_REG_IN, MEM_READ_IN, MEM_WRITE_IN, Reg_EN_IN,
           ALU_Result_IN, D_MEM_ADDR_IN, DataIN_MEM_IN, WB_REG_IN, out_ready,
    output in_ready, out_valid, MEM_to_REG_OUT, MEM_READ_OUT, MEM_WRITE_OUT,
           Reg_EN_OUT, ALU_Result_OUT, D_MEM_ADDR_OUT, DataIN_MEM_OUT,
           WB_REG_OUT, fwd_en, fwd_reg, fwd_data, occupancy
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM pipeline register.
//   clock : core clock, rising edge
//   reset : asynchronous, active-low
//   flush : synchronous kill of all held entries (beats accept/drain)
//   bus   : ex_mem_pipe_reg_if.slave -- in_valid/in_ready + EX payload,
//           out_valid/out_ready + MEM payload, forwarding tap, occupancy
// SKID_EN=1: main + skid entry, in_ready is registered (= skid empty), so
// EX never sees a combinational path from out_ready.
// SKID_EN=0: single entry, in_ready = out_ready | !out_valid.
module ex_mem_pipe_reg #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 10,
  parameter int RegAddrWidth = 5,
  parameter bit SKID_EN      = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  ex_mem_pipe_reg_if.slave   bus
);

  typedef struct packed {
    logic                    mem_to_reg;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_en;
    logic [DataWidth-1:0]    alu;
    logic [AddrWidth-1:0]    addr;
    logic [DataWidth-1:0]    wdata;
    logic [RegAddrWidth-1:0] wb_reg;
  } ent_t;

  ent_t in_ent, main_q;
  logic main_v, skid_v, in_rdy, accept, drain;

  assign in_ent = '{mem_to_reg: bus.MEM_to_REG_IN, mem_read: bus.MEM_READ_IN,
                    mem_write:  bus.MEM_WRITE_IN,  reg_en:   bus.Reg_EN_IN,
                    alu:        bus.ALU_Result_IN, addr:     bus.D_MEM_ADDR_IN,
                    wdata:      bus.DataIN_MEM_IN, wb_reg:   bus.WB_REG_IN};

  assign accept = bus.in_valid & in_rdy;
  assign drain  = main_v & bus.out_ready;

  generate
    if (SKID_EN) begin : g_skid
      ent_t skid_q;

      assign in_rdy = !skid_v;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
          main_q <= '0;
          skid_q <= '0;
        end else if (flush) begin
          // payload left stale on purpose; only the valid bits matter
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (drain && skid_v) begin
          // oldest buffered entry moves up; any same-cycle arrival refills skid
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= accept;
          if (accept) skid_q <= in_ent;
        end else if (accept && (!main_v || drain)) begin
          main_q <= in_ent;
          main_v <= 1'b1;
        end else if (accept) begin
          // main busy and not leaving: park in skid
          skid_q <= in_ent;
          skid_v <= 1'b1;
        end else if (drain) begin
          main_v <= 1'b0;
        end
      end
    end else begin : g_noskid
      assign in_rdy = bus.out_ready | !main_v;
      assign skid_v = 1'b0;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          main_v <= 1'b0;
          main_q <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
        end else if (accept) begin
          main_q <= in_ent;
          main_v <= 1'b1;
        end else if (drain) begin
          main_v <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.in_ready       = in_rdy;
  assign bus.out_valid      = main_v;
  assign bus.MEM_to_REG_OUT = main_v & main_q.mem_to_reg;
  assign bus.MEM_READ_OUT   = main_v & main_q.mem_read;
  assign bus.MEM_WRITE_OUT  = main_v & main_q.mem_write;
  assign bus.Reg_EN_OUT     = main_v & main_q.reg_en;
  assign bus.ALU_Result_OUT = main_q.alu;
  assign bus.D_MEM_ADDR_OUT = main_q.addr;
  assign bus.DataIN_MEM_OUT = main_q.wdata;
  assign bus.WB_REG_OUT     = main_q.wb_reg;

  // loads produce their value in MEM, so they cannot be forwarded from here
  assign bus.fwd_en   = main_v & main_q.reg_en & !main_q.mem_to_reg &
                        (main_q.wb_reg != '0);
  assign bus.fwd_reg  = main_q.wb_reg;
  assign bus.fwd_data = main_q.alu;

  assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush1 = 1'b0;
  logic flush0 = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clock = ~clock;

  ex_mem_pipe_reg_if #(.DataWidth(32), .AddrWidth(10), .RegAddrWidth(5)) b1 ();
  ex_mem_pipe_reg_if #(.DataWidth(32), .AddrWidth(10), .RegAddrWidth(5)) b0 ();

  ex_mem_pipe_reg #(.DataWidth(32), .AddrWidth(10), .RegAddrWidth(5), .SKID_EN(1'b1))
    dut1 (.clock(clock), .reset(reset), .flush(flush1), .bus(b1));
  ex_mem_pipe_reg #(.DataWidth(32), .AddrWidth(10), .RegAddrWidth(5), .SKID_EN(1'b0))
    dut0 (.clock(clock), .reset(reset), .flush(flush0), .bus(b0));

  typedef struct packed {
    logic        m2r, mr, mw, re;
    logic [31:0] alu;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [4:0]  wb;
  } pl_t;

  pl_t q[$];      // reference FIFO for the skid instance (capacity 2)
  bit  v0;        // reference slot for the single-entry instance
  pl_t e0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t mk(logic [31:0] alu, logic [4:0] wb, logic re, logic m2r, logic mw);
    pl_t p;
    p.m2r = m2r; p.mr = m2r; p.mw = mw; p.re = re;
    p.alu = alu; p.addr = alu[9:0] ^ 10'h155; p.wd = ~alu; p.wb = wb;
    return p;
  endfunction

  function automatic pl_t rnd();
    pl_t p;
    p.m2r = 1'($urandom); p.mr = 1'($urandom); p.mw = 1'($urandom); p.re = 1'($urandom);
    p.alu = $urandom; p.addr = 10'($urandom); p.wd = $urandom;
    p.wb = 5'($urandom_range(0, 3));
    return p;
  endfunction

  task automatic drive1(input bit v, input pl_t p);
    b1.in_valid = v; b1.MEM_to_REG_IN = p.m2r; b1.MEM_READ_IN = p.mr;
    b1.MEM_WRITE_IN = p.mw; b1.Reg_EN_IN = p.re; b1.ALU_Result_IN = p.alu;
    b1.D_MEM_ADDR_IN = p.addr; b1.DataIN_MEM_IN = p.wd; b1.WB_REG_IN = p.wb;
  endtask

  task automatic drive0(input bit v, input pl_t p);
    b0.in_valid = v; b0.MEM_to_REG_IN = p.m2r; b0.MEM_READ_IN = p.mr;
    b0.MEM_WRITE_IN = p.mw; b0.Reg_EN_IN = p.re; b0.ALU_Result_IN = p.alu;
    b0.D_MEM_ADDR_IN = p.addr; b0.DataIN_MEM_IN = p.wd; b0.WB_REG_IN = p.wb;
  endtask

  // one clock of the skid instance: check outputs against the FIFO model,
  // then apply the transfer the model predicts at the following edge
  task automatic step1();
    pl_t h, inp;
    bit  v, acc, drn, fl;
    @(negedge clock);
    v = (q.size() > 0);
    h = v ? q[0] : '0;
    chk("out_valid", 64'(b1.out_valid), 64'(v));
    chk("occupancy", 64'(b1.occupancy), 64'(q.size()));
    chk("in_ready", 64'(b1.in_ready), 64'(q.size() < 2));
    chk("mem_to_reg_out", 64'(b1.MEM_to_REG_OUT), 64'(v & h.m2r));
    chk("mem_read_out", 64'(b1.MEM_READ_OUT), 64'(v & h.mr));
    chk("mem_write_out", 64'(b1.MEM_WRITE_OUT), 64'(v & h.mw));
    chk("reg_en_out", 64'(b1.Reg_EN_OUT), 64'(v & h.re));
    chk("fwd_en", 64'(b1.fwd_en), 64'(v && h.re && !h.m2r && h.wb != 0));
    if (v) begin
      chk("alu_out", 64'(b1.ALU_Result_OUT), 64'(h.alu));
      chk("addr_out", 64'(b1.D_MEM_ADDR_OUT), 64'(h.addr));
      chk("wdata_out", 64'(b1.DataIN_MEM_OUT), 64'(h.wd));
      chk("wb_reg_out", 64'(b1.WB_REG_OUT), 64'(h.wb));
      chk("fwd_reg", 64'(b1.fwd_reg), 64'(h.wb));
      chk("fwd_data", 64'(b1.fwd_data), 64'(h.alu));
    end
    inp = {b1.MEM_to_REG_IN, b1.MEM_READ_IN, b1.MEM_WRITE_IN, b1.Reg_EN_IN,
           b1.ALU_Result_IN, b1.D_MEM_ADDR_IN, b1.DataIN_MEM_IN, b1.WB_REG_IN};
    acc = b1.in_valid && (q.size() < 2);
    drn = v && b1.out_ready;
    fl  = flush1;
    @(posedge clock);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(inp);
    end
    #1;
  endtask

  // one clock of the single-entry instance
  task automatic step0();
    pl_t inp;
    bit  acc, drn;
    @(negedge clock);
    chk("nsk_out_valid", 64'(b0.out_valid), 64'(v0));
    chk("nsk_occupancy", 64'(b0.occupancy), 64'(v0));
    chk("nsk_in_ready", 64'(b0.in_ready), 64'(b0.out_ready | !v0));
    chk("nsk_mem_write_out", 64'(b0.MEM_WRITE_OUT), 64'(v0 & e0.mw));
    if (v0) chk("nsk_alu_out", 64'(b0.ALU_Result_OUT), 64'(e0.alu));
    inp = {b0.MEM_to_REG_IN, b0.MEM_READ_IN, b0.MEM_WRITE_IN, b0.Reg_EN_IN,
           b0.ALU_Result_IN, b0.D_MEM_ADDR_IN, b0.DataIN_MEM_IN, b0.WB_REG_IN};
    acc = b0.in_valid && (b0.out_ready || !v0);
    drn = v0 && b0.out_ready;
    @(posedge clock);
    if (acc) begin v0 = 1'b1; e0 = inp; end
    else if (drn) v0 = 1'b0;
    #1;
  endtask

  initial begin
    pl_t z;
    z = '0;
    v0 = 1'b0; e0 = '0;
    drive1(1'b1, mk(32'hCAFE, 5'd3, 1'b1, 1'b0, 1'b1));
    drive0(1'b0, z);
    b1.out_ready = 1'b1;
    b0.out_ready = 1'b1;

    // reset asserted with in_valid=1: everything 0 except in_ready
    #3;
    chk("rst_in_ready", 64'(b1.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
    chk("rst_occupancy", 64'(b1.occupancy), 64'd0);
    chk("rst_ctrl", 64'({b1.MEM_to_REG_OUT, b1.MEM_READ_OUT, b1.MEM_WRITE_OUT, b1.Reg_EN_OUT}), 64'd0);
    chk("rst_alu", 64'(b1.ALU_Result_OUT), 64'd0);
    chk("rst_addr", 64'(b1.D_MEM_ADDR_OUT), 64'd0);
    chk("rst_wdata", 64'(b1.DataIN_MEM_OUT), 64'd0);
    chk("rst_wb", 64'(b1.WB_REG_OUT), 64'd0);
    chk("rst_fwd", 64'({b1.fwd_en, b1.fwd_reg, b1.fwd_data}), 64'd0);
    chk("rst_nsk_in_ready", 64'(b0.in_ready), 64'd1);
    @(posedge clock); @(posedge clock);
    chk("rst_hold_out_valid", 64'(b1.out_valid), 64'd0);
    @(negedge clock);
    drive1(1'b0, z);
    reset = 1'b1;
    @(posedge clock); #1;
    repeat (3) step1();

    // streaming with out_ready=1
    drive1(1'b1, mk(32'h10, 5'd1, 1'b1, 1'b0, 1'b0)); step1();
    drive1(1'b1, mk(32'h20, 5'd2, 1'b1, 1'b0, 1'b0)); step1();
    drive1(1'b1, mk(32'h30, 5'd3, 1'b1, 1'b0, 1'b0)); step1();
    drive1(1'b0, z); step1(); step1();

    // back-pressure fills both entries, C waits at EX
    b1.out_ready = 1'b0;
    drive1(1'b1, mk(32'h11, 5'd4, 1'b0, 1'b0, 1'b1)); step1();
    drive1(1'b1, mk(32'h22, 5'd5, 1'b0, 1'b0, 1'b1)); step1();
    drive1(1'b1, mk(32'h33, 5'd6, 1'b0, 1'b0, 1'b1)); step1(); step1();
    b1.out_ready = 1'b1;
    for (int i = 0; i < 6 && b1.in_valid; i++) begin
      step1();
      if (q.size() > 0 && q[q.size()-1].alu == 32'h33) drive1(1'b0, z);
    end
    repeat (3) step1();

    // flush with two entries held and a new instruction offered
    b1.out_ready = 1'b0;
    drive1(1'b1, mk(32'h55, 5'd1, 1'b0, 1'b0, 1'b1)); step1();
    drive1(1'b1, mk(32'h66, 5'd2, 1'b0, 1'b0, 1'b1)); step1();
    drive1(1'b1, mk(32'h44, 5'd3, 1'b0, 1'b0, 1'b1));
    flush1 = 1'b1; step1();
    flush1 = 1'b0; drive1(1'b0, z); step1();
    chk("flush_empty", 64'(b1.occupancy), 64'd0);
    b1.out_ready = 1'b1;
    step1();

    // forwarding tap
    drive1(1'b1, mk(32'hDEAD, 5'd7, 1'b1, 1'b0, 1'b0)); step1();
    drive1(1'b1, mk(32'hBEEF, 5'd0, 1'b1, 1'b0, 1'b0)); step1();
    drive1(1'b1, mk(32'hF00D, 5'd9, 1'b1, 1'b1, 1'b0)); step1();
    drive1(1'b0, z); step1(); step1();

    // randomized traffic against the FIFO model
    for (int i = 0; i < 300; i++) begin
      b1.out_ready = ($urandom_range(0, 3) != 0);
      flush1 = ($urandom_range(0, 31) == 0);
      drive1(($urandom_range(0, 3) != 0), rnd());
      step1();
    end
    flush1 = 1'b0;
    drive1(1'b0, z);

    // single-entry instance: combinational ready and random traffic
    b0.out_ready = 1'b0;
    drive0(1'b1, mk(32'h77, 5'd2, 1'b1, 1'b0, 1'b1)); step0();
    drive0(1'b0, z); step0();
    b0.out_ready = 1'b1; #1;
    chk("nsk_comb_ready", 64'(b0.in_ready), 64'd1);
    for (int i = 0; i < 60; i++) begin
      b0.out_ready = ($urandom_range(0, 2) != 0);
      drive0(($urandom_range(0, 3) != 0), rnd());
      step0();
    end
    b0.out_ready = 1'b0;
    drive0(1'b1, mk(32'h99, 5'd1, 1'b1, 1'b0, 1'b1)); step0();
    drive0(1'b0, z); step0();
    chk("nsk_hold_occ", 64'(b0.occupancy), 64'd1);
    chk("nsk_hold_ready", 64'(b0.in_ready), 64'd0);

    // async reset between edges
    @(negedge clock); #2;
    reset = 1'b0; #1;
    chk("async_rst_valid", 64'(b0.out_valid), 64'd0);
    chk("async_rst_occ", 64'(b0.occupancy), 64'd0);
    chk("async_rst_alu", 64'(b0.ALU_Result_OUT), 64'd0);
    chk("async_rst_ready", 64'(b0.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised, elastic EX/MEM pipeline register for the 5-stage core. It replaces the always-load register with a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush and a forwarding tap for the hazard unit. Sits between the ALU/branch stage and the data-memory stage, and can absorb one cycle of MEM back-pressure without stalling EX combinationally.

Parameters:
DataWidth, 32, ALU result and store-data width
AddrWidth, 10, data-memory address width
RegAddrWidth, 5, register-file index width
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with pass-through ready

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous kill of every held entry
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept this cycle
MEM_to_REG_IN, MEM_READ_IN, MEM_WRITE_IN, Reg_EN_IN  in  1 each  control bits
ALU_Result_IN  in  DataWidth  ALU result
D_MEM_ADDR_IN  in  AddrWidth  data-memory address
DataIN_MEM_IN  in  DataWidth  store data
WB_REG_IN  in  RegAddrWidth  destination register
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM stage consumes the entry this cycle
MEM_to_REG_OUT, MEM_READ_OUT, MEM_WRITE_OUT, Reg_EN_OUT  out  1 each  control bits, gated by out_valid
ALU_Result_OUT, D_MEM_ADDR_OUT, DataIN_MEM_OUT, WB_REG_OUT  out  as input  held payload
fwd_en  out  1  forwarding tap is usable
fwd_reg  out  RegAddrWidth  forwarding destination register
fwd_data  out  DataWidth  forwarding value (ALU_Result of the main entry)
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives all *_OUT), plus skid entry when SKID_EN=1. Each entry has its own valid bit.
- Reset, asynchronous on reset=0: both valid bits clear and all payload clears to 0. Every output is then 0, except in_ready, which is 1.
- Transfer rules: accept = in_valid & in_ready; drain = out_valid & out_ready.
- SKID_EN=1 (registered ready):
  - in_ready = !skid_valid.
  - On accept: load main if main is empty or drain is asserted (and skid is empty); otherwise load skid.
  - On drain with skid valid: main takes skid, and skid clears. If accept occurs in the same cycle, the new entry goes to skid.
  - Order is strictly FIFO, and no entry is duplicated or dropped.
- SKID_EN=0:
  - in_ready = out_ready | !out_valid (combinational).
  - On accept, main loads. On drain without accept, main valid clears.
- Latency: 1 cycle from accept to out_valid when main is empty.
- Throughput: 1 entry per cycle while out_ready=1.
- Flush: clears both valid bits at the clock edge and wins over any simultaneous accept or drain. Payload registers may keep stale data. in_ready during the flush cycle follows the pre-flush state.
- Gating:
  - MEM_READ_OUT, MEM_WRITE_OUT, Reg_EN_OUT and MEM_to_REG_OUT are 0 whenever out_valid=0.
  - Data/address outputs are ungated.
- Forwarding: fwd_en = out_valid & Reg_EN_OUT & !MEM_to_REG_OUT & (WB_REG_OUT != 0). Loads are not forwardable from this stage. fwd_reg = WB_REG_OUT; fwd_data = ALU_Result_OUT.
- occupancy = main_valid + skid_valid; it is always 0 or 1 when SKID_EN=0.
- Held payload stays stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all entries immediately, with no clock edge required.

Test Plan:
- Reset/idle: drive reset=0 with in_valid=1 -> all outputs 0 and in_ready=1. Release reset with in_valid=0 for 3 cycles -> out_valid stays 0.
- Streaming, out_ready=1: accept ALU_Result 0x10, 0x20, 0x30 on consecutive cycles -> each appears 1 cycle later, occupancy 1, no bubbles.
- Back-pressure (SKID_EN=1): out_ready=0, send A=0x11 then B=0x22 -> occupancy 2, in_ready=0, C=0x33 held by EX. Raise out_ready -> outputs A, B, C in order; in_ready returns to 1 one cycle after the first drain.
- Flush: with 2 entries held, assert flush together with in_valid (0x44) -> next cycle out_valid=0, occupancy 0, MEM_WRITE_OUT=0, and 0x44 is discarded.
- Forwarding: accept Reg_EN=1, WB_REG=7, ALU=0xDEAD, MEM_to_REG=0 -> fwd_en=1, fwd_reg=7, fwd_data=0xDEAD. Repeat with WB_REG=0 or MEM_to_REG=1 -> fwd_en=0.
- SKID_EN=0 plus async reset: hold out_ready=0 -> in_ready=0 and occupancy 1. Pulse reset low mid-cycle -> out_valid falls immediately, before the next clock edge.
